// File: rtl/decode_stage_pipe.sv
// RV32I/RV32E decode stage with internal register file and a registered ID/EX slot.
// Optional macro DECODE_BYPASS_EN forwards same-cycle writeback data into captured operands.

module opcode_decoder (
   input  logic [6:0] opcode,
   output logic       branch,
   output logic       mem_read,
   output logic       mem_to_reg,
   output logic       mem_write,
   output logic       alu_src,
   output logic       reg_write,
   output logic [1:0] jump,
   output logic [2:0] alu_op,
   output logic       rs1_used,
   output logic       rs2_used,
   output logic       rd_used,
   output logic       known
);
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   // alu_op: 000 add, 001 branch compare, 010 R-type, 011 I-type, 100 pass immediate
   always_comb begin
      branch     = 1'b0;
      mem_read   = 1'b0;
      mem_to_reg = 1'b0;
      mem_write  = 1'b0;
      alu_src    = 1'b0;
      reg_write  = 1'b0;
      jump       = 2'b00;
      alu_op     = 3'b000;
      rs1_used   = 1'b0;
      rs2_used   = 1'b0;
      rd_used    = 1'b0;
      known      = 1'b1;
      case (opcode)
         OP_R: begin
            reg_write = 1'b1;
            alu_op    = 3'b010;
            rs1_used  = 1'b1;
            rs2_used  = 1'b1;
            rd_used   = 1'b1;
         end
         OP_I: begin
            alu_src   = 1'b1;
            reg_write = 1'b1;
            alu_op    = 3'b011;
            rs1_used  = 1'b1;
            rd_used   = 1'b1;
         end
         OP_LOAD: begin
            mem_read   = 1'b1;
            mem_to_reg = 1'b1;
            alu_src    = 1'b1;
            reg_write  = 1'b1;
            rs1_used   = 1'b1;
            rd_used    = 1'b1;
         end
         OP_STORE: begin
            mem_write = 1'b1;
            alu_src   = 1'b1;
            rs1_used  = 1'b1;
            rs2_used  = 1'b1;
         end
         OP_BRANCH: begin
            branch   = 1'b1;
            alu_op   = 3'b001;
            rs1_used = 1'b1;
            rs2_used = 1'b1;
         end
         OP_JAL: begin
            reg_write = 1'b1;
            jump      = 2'b01;
            rd_used   = 1'b1;
         end
         OP_JALR: begin
            reg_write = 1'b1;
            jump      = 2'b10;
            alu_src   = 1'b1;
            rs1_used  = 1'b1;
            rd_used   = 1'b1;
         end
         OP_LUI: begin
            reg_write = 1'b1;
            alu_src   = 1'b1;
            alu_op    = 3'b100;
            rd_used   = 1'b1;
         end
         OP_AUIPC: begin
            reg_write = 1'b1;
            alu_src   = 1'b1;
            rd_used   = 1'b1;
         end
         default: known = 1'b0;
      endcase
   end
endmodule

module alu_decoder (
   input  logic [2:0] alu_op,
   input  logic [2:0] funct3,
   input  logic       funct7_b5,
   output logic [3:0] alu_control
);
   localparam logic [3:0] ALU_ADD    = 4'd0;
   localparam logic [3:0] ALU_SUB    = 4'd1;
   localparam logic [3:0] ALU_SLL    = 4'd2;
   localparam logic [3:0] ALU_SLT    = 4'd3;
   localparam logic [3:0] ALU_SLTU   = 4'd4;
   localparam logic [3:0] ALU_XOR    = 4'd5;
   localparam logic [3:0] ALU_SRL    = 4'd6;
   localparam logic [3:0] ALU_SRA    = 4'd7;
   localparam logic [3:0] ALU_OR     = 4'd8;
   localparam logic [3:0] ALU_AND    = 4'd9;
   localparam logic [3:0] ALU_PASS_B = 4'd10;

   logic [3:0] arith;

   always_comb begin
      arith = ALU_ADD;
      case (funct3)
         3'b000: arith = (alu_op == 3'b010 && funct7_b5) ? ALU_SUB : ALU_ADD;
         3'b001: arith = ALU_SLL;
         3'b010: arith = ALU_SLT;
         3'b011: arith = ALU_SLTU;
         3'b100: arith = ALU_XOR;
         3'b101: arith = funct7_b5 ? ALU_SRA : ALU_SRL;
         3'b110: arith = ALU_OR;
         3'b111: arith = ALU_AND;
         default: arith = ALU_ADD;
      endcase
   end

   always_comb begin
      alu_control = ALU_ADD;
      case (alu_op)
         3'b001: begin
            case (funct3)
               3'b100, 3'b101: alu_control = ALU_SLT;
               3'b110, 3'b111: alu_control = ALU_SLTU;
               default:        alu_control = ALU_SUB;
            endcase
         end
         3'b010, 3'b011: alu_control = arith;
         3'b100:         alu_control = ALU_PASS_B;
         default:        alu_control = ALU_ADD;
      endcase
   end
endmodule

module imm_gen (
   input  logic [31:0] instr,
   output logic [31:0] imm
);
   always_comb begin
      imm = 32'd0;
      case (instr[6:0])
         7'b0010011, 7'b0000011, 7'b1100111:
            imm = {{20{instr[31]}}, instr[31:20]};
         7'b0100011:
            imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         7'b1100011:
            imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         7'b0110111, 7'b0010111:
            imm = {instr[31:12], 12'd0};
         7'b1101111:
            imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default:
            imm = 32'd0;
      endcase
   end
endmodule

module decode_stage_pipe #(
   parameter int XLEN     = 32,
   parameter int NUM_REGS = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   input  logic            flush,
   input  logic            wb_we,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [4:0]      out_rs1,
   output logic [4:0]      out_rs2,
   output logic [4:0]      out_rd,
   output logic [XLEN-1:0] out_rs1_data,
   output logic [XLEN-1:0] out_rs2_data,
   output logic [XLEN-1:0] out_imm,
   output logic [3:0]      out_alu_control,
   output logic            out_branch,
   output logic            out_mem_read,
   output logic            out_mem_to_reg,
   output logic            out_mem_write,
   output logic            out_alu_src,
   output logic            out_reg_write,
   output logic [1:0]      out_jump,
   output logic            out_illegal
);
   localparam int         IDX_W      = $clog2(NUM_REGS);
   localparam logic [5:0] NUM_REGS_L = 6'(NUM_REGS);

   logic [XLEN-1:0] regs [NUM_REGS];

   logic [4:0]      rs1, rs2, rd;
   logic            dec_branch, dec_mem_read, dec_mem_to_reg, dec_mem_write;
   logic            dec_alu_src, dec_reg_write;
   logic [1:0]      dec_jump;
   logic [2:0]      dec_alu_op;
   logic            rs1_used, rs2_used, rd_used, known;
   logic [3:0]      dec_alu_control;
   logic [31:0]     imm32;
   logic [XLEN-1:0] imm_ext;
   logic            rs1_oob, rs2_oob, rd_oob, illegal;
   logic [XLEN-1:0] rs1_rf, rs2_rf, rs1_val, rs2_val;
   logic            wb_ok, hazard, accept;

   assign rs1 = in_instr[19:15];
   assign rs2 = in_instr[24:20];
   assign rd  = in_instr[11:7];

   opcode_decoder u_opcode_decoder (
      .opcode     (in_instr[6:0]),
      .branch     (dec_branch),
      .mem_read   (dec_mem_read),
      .mem_to_reg (dec_mem_to_reg),
      .mem_write  (dec_mem_write),
      .alu_src    (dec_alu_src),
      .reg_write  (dec_reg_write),
      .jump       (dec_jump),
      .alu_op     (dec_alu_op),
      .rs1_used   (rs1_used),
      .rs2_used   (rs2_used),
      .rd_used    (rd_used),
      .known      (known)
   );

   alu_decoder u_alu_decoder (
      .alu_op      (dec_alu_op),
      .funct3      (in_instr[14:12]),
      .funct7_b5   (in_instr[30]),
      .alu_control (dec_alu_control)
   );

   imm_gen u_imm_gen (
      .instr (in_instr),
      .imm   (imm32)
   );

   assign imm_ext = XLEN'($signed(imm32));

   assign rs1_oob = ({1'b0, rs1} >= NUM_REGS_L);
   assign rs2_oob = ({1'b0, rs2} >= NUM_REGS_L);
   assign rd_oob  = ({1'b0, rd}  >= NUM_REGS_L);
   assign illegal = ~known | (rs1_used & rs1_oob) | (rs2_used & rs2_oob) | (rd_used & rd_oob);

   assign wb_ok = wb_we & (wb_rd != 5'd0) & ({1'b0, wb_rd} < NUM_REGS_L);

   // Out-of-range indices read as zero; they are flagged illegal when actually used.
   always_comb begin
      rs1_rf = '0;
      rs2_rf = '0;
      if (rs1 != 5'd0 && !rs1_oob) rs1_rf = regs[rs1[IDX_W-1:0]];
      if (rs2 != 5'd0 && !rs2_oob) rs2_rf = regs[rs2[IDX_W-1:0]];
   end

`ifdef DECODE_BYPASS_EN
   assign rs1_val = (wb_ok && wb_rd == rs1) ? wb_data : rs1_rf;
   assign rs2_val = (wb_ok && wb_rd == rs2) ? wb_data : rs2_rf;
`else
   assign rs1_val = rs1_rf;
   assign rs2_val = rs2_rf;
`endif

   assign hazard = out_valid & out_mem_read & (out_rd != 5'd0) &
                   ((out_rd == rs1) | ((out_rd == rs2) & rs2_used));
   assign in_ready = (~out_valid | out_ready) & ~hazard;
   assign accept   = in_valid & in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (wb_ok) begin
         regs[wb_rd[IDX_W-1:0]] <= wb_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid       <= 1'b0;
         out_pc          <= '0;
         out_rs1         <= '0;
         out_rs2         <= '0;
         out_rd          <= '0;
         out_rs1_data    <= '0;
         out_rs2_data    <= '0;
         out_imm         <= '0;
         out_alu_control <= '0;
         out_branch      <= 1'b0;
         out_mem_read    <= 1'b0;
         out_mem_to_reg  <= 1'b0;
         out_mem_write   <= 1'b0;
         out_alu_src     <= 1'b0;
         out_reg_write   <= 1'b0;
         out_jump        <= 2'b00;
         out_illegal     <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (accept) begin
         // Illegal instructions still occupy the slot so execute can raise a trap.
         out_valid       <= 1'b1;
         out_pc          <= in_pc;
         out_rs1         <= rs1;
         out_rs2         <= rs2;
         out_rd          <= rd;
         out_rs1_data    <= rs1_val;
         out_rs2_data    <= rs2_val;
         out_imm         <= imm_ext;
         out_alu_control <= dec_alu_control;
         out_branch      <= dec_branch     & ~illegal;
         out_mem_read    <= dec_mem_read   & ~illegal;
         out_mem_to_reg  <= dec_mem_to_reg;
         out_mem_write   <= dec_mem_write  & ~illegal;
         out_alu_src     <= dec_alu_src;
         out_reg_write   <= dec_reg_write  & ~illegal;
         out_jump        <= illegal ? 2'b00 : dec_jump;
         out_illegal     <= illegal;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
`ifdef DECODE_BYPASS_EN
      else if (out_valid) begin
         if (wb_ok && wb_rd == out_rs1) out_rs1_data <= wb_data;
         if (wb_ok && wb_rd == out_rs2) out_rs2_data <= wb_data;
      end
`endif
   end
endmodule

// File: tb/tb_decode_stage_pipe.sv
// Scoreboard bench for decode_stage_pipe: RV32I instance with queued expectations,
// plus a small RV32E instance for register-range checks.

module tb_decode_stage_pipe;
   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] d1;
      logic [31:0] d2;
      logic [31:0] imm;
      logic [3:0]  alu;
      logic [5:0]  ctl;
      logic [1:0]  jump;
      logic        illegal;
   } exp_t;

   // ctl bits: {branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write}
   localparam logic [5:0] C_BR = 6'b100000;
   localparam logic [5:0] C_MR = 6'b010000;
   localparam logic [5:0] C_M2 = 6'b001000;
   localparam logic [5:0] C_MW = 6'b000100;
   localparam logic [5:0] C_AS = 6'b000010;
   localparam logic [5:0] C_RW = 6'b000001;

`ifdef DECODE_BYPASS_EN
   localparam logic [31:0] BYP_X3 = 32'h0000_00AA;
`else
   localparam logic [31:0] BYP_X3 = 32'h0000_0000;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0, in_ready;
   logic [31:0] in_instr = '0, in_pc = '0;
   logic        flush = 1'b0, wb_we = 1'b0;
   logic [4:0]  wb_rd = '0;
   logic [31:0] wb_data = '0;
   logic        out_valid, out_ready = 1'b1;
   logic [31:0] out_pc, out_rs1_data, out_rs2_data, out_imm;
   logic [4:0]  out_rs1, out_rs2, out_rd;
   logic [3:0]  out_alu_control;
   logic        out_branch, out_mem_read, out_mem_to_reg, out_mem_write;
   logic        out_alu_src, out_reg_write, out_illegal;
   logic [1:0]  out_jump;

   logic        e_in_valid = 1'b0, e_in_ready;
   logic [31:0] e_in_instr = '0, e_in_pc = '0;
   logic        e_flush = 1'b0, e_wb_we = 1'b0;
   logic [4:0]  e_wb_rd = '0;
   logic [31:0] e_wb_data = '0;
   logic        e_out_valid, e_out_ready = 1'b1;
   logic [31:0] e_out_pc, e_out_rs1_data, e_out_rs2_data, e_out_imm;
   logic [4:0]  e_out_rs1, e_out_rs2, e_out_rd;
   logic [3:0]  e_out_alu_control;
   logic        e_out_branch, e_out_mem_read, e_out_mem_to_reg, e_out_mem_write;
   logic        e_out_alu_src, e_out_reg_write, e_out_illegal;
   logic [1:0]  e_out_jump;

   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t exp_q[$];
   string name_q[$];

   always #5 clk = ~clk;

   decode_stage_pipe #(.XLEN(32), .NUM_REGS(32)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
      .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
      .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_imm(out_imm),
      .out_alu_control(out_alu_control), .out_branch(out_branch),
      .out_mem_read(out_mem_read), .out_mem_to_reg(out_mem_to_reg),
      .out_mem_write(out_mem_write), .out_alu_src(out_alu_src),
      .out_reg_write(out_reg_write), .out_jump(out_jump), .out_illegal(out_illegal)
   );

   decode_stage_pipe #(.XLEN(32), .NUM_REGS(16)) u_dut_e (
      .clk(clk), .rst(rst), .in_valid(e_in_valid), .in_ready(e_in_ready),
      .in_instr(e_in_instr), .in_pc(e_in_pc), .flush(e_flush),
      .wb_we(e_wb_we), .wb_rd(e_wb_rd), .wb_data(e_wb_data),
      .out_valid(e_out_valid), .out_ready(e_out_ready), .out_pc(e_out_pc),
      .out_rs1(e_out_rs1), .out_rs2(e_out_rs2), .out_rd(e_out_rd),
      .out_rs1_data(e_out_rs1_data), .out_rs2_data(e_out_rs2_data), .out_imm(e_out_imm),
      .out_alu_control(e_out_alu_control), .out_branch(e_out_branch),
      .out_mem_read(e_out_mem_read), .out_mem_to_reg(e_out_mem_to_reg),
      .out_mem_write(e_out_mem_write), .out_alu_src(e_out_alu_src),
      .out_reg_write(e_out_reg_write), .out_jump(e_out_jump), .out_illegal(e_out_illegal)
   );

   function automatic exp_t mk(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                               input logic [31:0] imm, input logic [3:0] alu, input logic [5:0] ctl,
                               input logic [1:0] jump, input logic illegal);
      exp_t e;
      e.pc = pc; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.d1 = d1; e.d2 = d2;
      e.imm = imm; e.alu = alu; e.ctl = ctl; e.jump = jump; e.illegal = illegal;
      return e;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wb(input logic [4:0] rd, input logic [31:0] data);
      wb_we = 1'b1; wb_rd = rd; wb_data = data;
      step();
      wb_we = 1'b0;
   endtask

   task automatic e_wb(input logic [4:0] rd, input logic [31:0] data);
      e_wb_we = 1'b1; e_wb_rd = rd; e_wb_data = data;
      step();
      e_wb_we = 1'b0;
   endtask

   task automatic send(input string nm, input logic [31:0] instr, input logic [31:0] pc, input exp_t e);
      bit ok = 1'b0;
      in_valid = 1'b1; in_instr = instr; in_pc = pc;
      for (int n = 0; n < 20 && !ok; n++) begin
         @(negedge clk);
         if (in_ready) begin
            exp_q.push_back(e);
            name_q.push_back(nm);
            ok = 1'b1;
         end
         step();
      end
      in_valid = 1'b0;
      if (!ok) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: in_ready stayed 0 for 20 cycles, required 1", nm);
      end
   endtask

   // Monitor: every consumed slot is compared against the oldest queued expectation.
   always @(negedge clk) begin
      exp_t  e, a;
      string nm;
      if (!rst && out_valid && out_ready && !flush) begin
         a = mk(out_pc, out_rs1, out_rs2, out_rd, out_rs1_data, out_rs2_data, out_imm,
                out_alu_control,
                {out_branch, out_mem_read, out_mem_to_reg, out_mem_write, out_alu_src, out_reg_write},
                out_jump, out_illegal);
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_slot: got %h expected no valid slot", a);
         end else begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            if (a !== e) begin
               n_fail++;
               $display("FAIL %s: got %h expected %h", nm, a, e);
            end
         end
      end
   end

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      @(negedge clk);
      check("reset_out_zero", 32'(|{out_valid, out_pc, out_rs1, out_rs2, out_rd, out_rs1_data,
            out_rs2_data, out_imm, out_alu_control, out_branch, out_mem_read, out_mem_to_reg,
            out_mem_write, out_alu_src, out_reg_write, out_jump, out_illegal}), 32'd0);
      check("reset_in_ready", 32'(in_ready), 32'd1);
      step();

      send("add_x10_zero_regs", 32'h01F08533, 32'h100,
           mk(32'h100, 5'd1, 5'd31, 5'd10, 32'h0, 32'h0, 32'h0, 4'd0, C_RW, 2'b00, 1'b0));

      wb(5'd5, 32'h1234);
      wb(5'd2, 32'h10);
      wb(5'd1, 32'h100);

      send("addi_x6_x5_7", 32'h00728313, 32'h104,
           mk(32'h104, 5'd5, 5'd7, 5'd6, 32'h1234, 32'h0, 32'h7, 4'd0, C_AS | C_RW, 2'b00, 1'b0));
      send("addi_neg_imm", 32'hFFF10613, 32'h108,
           mk(32'h108, 5'd2, 5'd31, 5'd12, 32'h10, 32'h0, 32'hFFFF_FFFF, 4'd0, C_AS | C_RW, 2'b00, 1'b0));
      send("sw_x2_8_x1", 32'h0020A423, 32'h10C,
           mk(32'h10C, 5'd1, 5'd2, 5'd8, 32'h100, 32'h10, 32'h8, 4'd0, C_MW | C_AS, 2'b00, 1'b0));
      send("beq_back_4", 32'hFE208EE3, 32'h110,
           mk(32'h110, 5'd1, 5'd2, 5'd29, 32'h100, 32'h10, 32'hFFFF_FFFC, 4'd1, C_BR, 2'b00, 1'b0));
      send("jal_x1_16", 32'h010000EF, 32'h114,
           mk(32'h114, 5'd0, 5'd16, 5'd1, 32'h0, 32'h0, 32'h10, 4'd0, C_RW, 2'b01, 1'b0));
      send("lui_x13", 32'h123456B7, 32'h118,
           mk(32'h118, 5'd8, 5'd3, 5'd13, 32'h0, 32'h0, 32'h1234_5000, 4'd10, C_AS | C_RW, 2'b00, 1'b0));

      // Load-use: lw x7 then add x8,x7,x2 stalls one cycle behind a bubble.
      send("lw_x7", 32'h0000A383, 32'h11C,
           mk(32'h11C, 5'd1, 5'd0, 5'd7, 32'h100, 32'h0, 32'h0, 4'd0, C_MR | C_M2 | C_AS | C_RW, 2'b00, 1'b0));
      in_valid = 1'b1; in_instr = 32'h00238433; in_pc = 32'h120;
      @(negedge clk);
      check("hazard_in_ready", 32'(in_ready), 32'd0);
      check("hazard_slot_valid", 32'(out_valid), 32'd1);
      step();
      @(negedge clk);
      check("hazard_bubble_valid", 32'(out_valid), 32'd0);
      check("hazard_release_ready", 32'(in_ready), 32'd1);
      exp_q.push_back(mk(32'h120, 5'd7, 5'd2, 5'd8, 32'h0, 32'h10, 32'h0, 4'd0, C_RW, 2'b00, 1'b0));
      name_q.push_back("add_after_load");
      step();
      in_valid = 1'b0;

      // rs2 field of an I-type matching the load rd must not stall.
      send("lw_x7_again", 32'h0000A383, 32'h200,
           mk(32'h200, 5'd1, 5'd0, 5'd7, 32'h100, 32'h0, 32'h0, 4'd0, C_MR | C_M2 | C_AS | C_RW, 2'b00, 1'b0));
      in_valid = 1'b1; in_instr = 32'h00708813; in_pc = 32'h204;
      @(negedge clk);
      check("no_hazard_itype_rs2", 32'(in_ready), 32'd1);
      if (in_ready) begin
         exp_q.push_back(mk(32'h204, 5'd1, 5'd7, 5'd16, 32'h100, 32'h0, 32'h7, 4'd0, C_AS | C_RW, 2'b00, 1'b0));
         name_q.push_back("addi_after_load");
      end
      step();
      in_valid = 1'b0;
      repeat (2) step();

      // Held slot, then flush while held.
      out_ready = 1'b0;
      send("sub_held", 32'h40228733, 32'h124,
           mk(32'h124, 5'd5, 5'd2, 5'd14, 32'h1234, 32'h10, 32'h0, 4'd1, C_RW, 2'b00, 1'b0));
      in_valid = 1'b1; in_instr = 32'h002087B3; in_pc = 32'h128;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("hold_in_ready", 32'(in_ready), 32'd0);
         check("hold_out_pc", out_pc, 32'h124);
         check("hold_rs1_data", out_rs1_data, 32'h1234);
         step();
      end
      flush = 1'b1;
      step();
      flush = 1'b0; in_valid = 1'b0;
      void'(exp_q.pop_back());
      void'(name_q.pop_back());
      @(negedge clk);
      check("flush_clears_valid", 32'(out_valid), 32'd0);
      out_ready = 1'b1;
      step();
      @(negedge clk);
      check("flush_drops_offer", 32'(out_valid), 32'd0);
      step();

      // Flush together with a transfer into an empty slot: consumed but not loaded.
      in_valid = 1'b1; in_instr = 32'h002087B3; in_pc = 32'h128; flush = 1'b1;
      @(negedge clk);
      check("flush_offer_ready", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0; flush = 1'b0;
      @(negedge clk);
      check("flush_offer_dropped", 32'(out_valid), 32'd0);
      step();

      send("illegal_opcode_7f", 32'h0020807F, 32'h12C,
           mk(32'h12C, 5'd1, 5'd2, 5'd0, 32'h100, 32'h10, 32'h0, 4'd0, 6'b0, 2'b00, 1'b1));

      wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'hAA;
      send("same_cycle_wb_x3", 32'h00018233, 32'h130,
           mk(32'h130, 5'd3, 5'd0, 5'd4, BYP_X3, 32'h0, 32'h0, 4'd0, C_RW, 2'b00, 1'b0));
      wb_we = 1'b0;
      send("read_x3_after_wb", 32'h00018233, 32'h134,
           mk(32'h134, 5'd3, 5'd0, 5'd4, 32'hAA, 32'h0, 32'h0, 4'd0, C_RW, 2'b00, 1'b0));

      wb(5'd0, 32'h99);
      send("x0_ignores_write", 32'h005004B3, 32'h138,
           mk(32'h138, 5'd0, 5'd5, 5'd9, 32'h0, 32'h1234, 32'h0, 4'd0, C_RW, 2'b00, 1'b0));
      repeat (3) step();

      // RV32E instance.
      e_wb(5'd1, 32'h21);
      e_wb(5'd17, 32'h55);
      e_in_valid = 1'b1; e_in_instr = 32'h002088B3; e_in_pc = 32'h40;
      @(negedge clk);
      check("e_in_ready", 32'(e_in_ready), 32'd1);
      step();
      e_in_valid = 1'b1; e_in_instr = 32'h002082B3; e_in_pc = 32'h44;
      @(negedge clk);
      check("e_illegal_valid", 32'(e_out_valid), 32'd1);
      check("e_illegal_flag", 32'(e_out_illegal), 32'd1);
      check("e_illegal_reg_write", 32'(e_out_reg_write), 32'd0);
      check("e_illegal_rd", 32'(e_out_rd), 32'd17);
      step();
      e_in_valid = 1'b0;
      @(negedge clk);
      check("e_legal_flag", 32'(e_out_illegal), 32'd0);
      check("e_legal_reg_write", 32'(e_out_reg_write), 32'd1);
      check("e_x1_not_clobbered", e_out_rs1_data, 32'h21);
      step();

      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL global_timeout: simulation exceeded 50000 time units, required earlier finish");
      $fatal(1, "timeout");
   end
endmodule
